// File: rtl/timing_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : timing_sequencer
// Purpose  : CNT_W-bit timing counter with one-hot T decode, run-time LIMIT,
//            wrap strobe and active flag. Optional macro SEQ_ICNT_EN adds
//            the INSTR_CNT completed-sequence counter.
// Revision : 1.0
// ============================================================================
module timing_sequencer #(
    parameter int CNT_W  = 4,
    parameter int NUM_T  = 2**CNT_W,
    parameter int ICNT_W = 16
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             SC,
    input  logic             INC,
    input  logic [CNT_W-1:0] LIMIT,
    output logic [CNT_W-1:0] SEQ_CNT,
    output logic [NUM_T-1:0] T,
    output logic             WRAP,
    output logic             ACTIVE
`ifdef SEQ_ICNT_EN
    ,
    output logic [ICNT_W-1:0] INSTR_CNT
`endif
);

    logic [CNT_W-1:0] seq_cnt_q, seq_cnt_d;
    logic             wrap_q, wrap_d;

    // NUM_T is derived; this empty block only exists when it is mis-set.
    if ((NUM_T != 2**CNT_W) || (ICNT_W < 1)) begin : g_bad_params
    end

    // The >= compare also catches LIMIT dropped below the current count.
    always_comb begin
        seq_cnt_d = seq_cnt_q;
        wrap_d    = 1'b0;
        if (SC) begin
            seq_cnt_d = '0;
        end else if (INC) begin
            if (seq_cnt_q >= LIMIT) begin
                seq_cnt_d = '0;
                wrap_d    = 1'b1;
            end else begin
                seq_cnt_d = seq_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            seq_cnt_q <= '0;
            wrap_q    <= 1'b0;
        end else begin
            seq_cnt_q <= seq_cnt_d;
            wrap_q    <= wrap_d;
        end
    end

    always_comb begin
        T          = '0;
        T[seq_cnt_q] = 1'b1;
    end

    assign SEQ_CNT = seq_cnt_q;
    assign WRAP    = wrap_q;
    assign ACTIVE  = (seq_cnt_q != '0);

`ifdef SEQ_ICNT_EN
    logic [ICNT_W-1:0] icnt_q, icnt_d;

    // A sequence completes on a wrap or on an SC that leaves a non-T0 state.
    always_comb begin
        icnt_d = icnt_q;
        if (wrap_d || (SC && (seq_cnt_q != '0))) begin
            icnt_d = icnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            icnt_q <= '0;
        end else begin
            icnt_q <= icnt_d;
        end
    end

    assign INSTR_CNT = icnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_timing_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_timing_sequencer
// Purpose  : Directed self-checking bench for timing_sequencer (CNT_W=4).
// Revision : 1.0
// ============================================================================
module tb_timing_sequencer;

    logic        CLK = 1'b0;
    logic        CLR_N;
    logic        SC;
    logic        INC;
    logic [3:0]  LIMIT;
    logic [3:0]  SEQ_CNT;
    logic [15:0] T;
    logic        WRAP;
    logic        ACTIVE;
`ifdef SEQ_ICNT_EN
    logic [15:0] INSTR_CNT;
    int          exp_icnt;
`endif

    int n_pass  = 0;
    int n_check = 0;

    timing_sequencer #(.CNT_W(4), .ICNT_W(16)) dut (
        .CLK     (CLK),
        .CLR_N   (CLR_N),
        .SC      (SC),
        .INC     (INC),
        .LIMIT   (LIMIT),
        .SEQ_CNT (SEQ_CNT),
        .T       (T),
        .WRAP    (WRAP),
        .ACTIVE  (ACTIVE)
`ifdef SEQ_ICNT_EN
        ,
        .INSTR_CNT (INSTR_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_check++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_state(input string tag, input int cnt, input logic wrap);
        logic [31:0] one;
        one = 32'd1;
        chk({tag, "_cnt"},  {28'd0, SEQ_CNT}, 32'(cnt));
        chk({tag, "_t"},    {16'd0, T},       one << cnt);
        chk({tag, "_wrap"}, {31'd0, WRAP},    {31'd0, wrap});
        chk({tag, "_act"},  {31'd0, ACTIVE},  {31'd0, (cnt != 0)});
    endtask

    initial begin
        CLR_N = 1'b0; SC = 1'b0; INC = 1'b0; LIMIT = 4'd15;
        #2;
        chk_state("reset", 0, 1'b0);
`ifdef SEQ_ICNT_EN
        exp_icnt = 0;
        chk("reset_icnt", {16'd0, INSTR_CNT}, 32'd0);
`endif
        step(); step();
        CLR_N = 1'b1;

        // 1: async reset mid-count, no edge
        INC = 1'b1;
        repeat (5) step();
        chk_state("pre_clr", 5, 1'b0);
        INC = 1'b0;
        CLR_N = 1'b0;
        #1;
        chk_state("async_clr", 0, 1'b0);
        step();
        CLR_N = 1'b1;

        // 2: full 16-state sequence
        LIMIT = 4'd15; INC = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            step();
            chk_state("full", i % 16, (i == 16));
        end
`ifdef SEQ_ICNT_EN
        exp_icnt = 1;
`endif

        // 3: LIMIT=3 after SC from count 1
        SC = 1'b1; INC = 1'b0;
        step();
        SC = 1'b0;
        chk_state("sc_from1", 0, 1'b0);
        LIMIT = 4'd3; INC = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk_state("lim3", i % 4, (i == 4));
        end
`ifdef SEQ_ICNT_EN
        exp_icnt = 3;
        chk("lim3_icnt", {16'd0, INSTR_CNT}, 32'(exp_icnt));
`endif

        // 4: SC beats INC at count 6
        LIMIT = 4'd15;
        repeat (4) step();
        chk_state("at6", 6, 1'b0);
        SC = 1'b1;
        step();
        SC = 1'b0;
        chk_state("sc_inc", 0, 1'b0);
`ifdef SEQ_ICNT_EN
        exp_icnt = 4;
        chk("sc_icnt", {16'd0, INSTR_CNT}, 32'(exp_icnt));
`endif

        // 5: lower LIMIT below count; also hold at non-zero count
        repeat (9) step();
        chk_state("at9", 9, 1'b0);
        INC = 1'b0;
        step();
        chk_state("hold9", 9, 1'b0);
        LIMIT = 4'd4; INC = 1'b1;
        step();
        chk_state("lowered", 0, 1'b1);
        INC = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state("hold0", 0, 1'b0);
        end
`ifdef SEQ_ICNT_EN
        exp_icnt = 5;
        chk("lowered_icnt", {16'd0, INSTR_CNT}, 32'(exp_icnt));
`endif

        // 6: LIMIT=0 wraps every INC edge
        LIMIT = 4'd0; INC = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_state("lim0", 0, 1'b1);
        end
`ifdef SEQ_ICNT_EN
        exp_icnt = 9;
        chk("lim0_icnt", {16'd0, INSTR_CNT}, 32'(exp_icnt));
`endif

        // reset while WRAP is high clears it immediately
        INC = 1'b0;
        CLR_N = 1'b0;
        #1;
        chk_state("clr_wrap", 0, 1'b0);
`ifdef SEQ_ICNT_EN
        chk("clr_icnt", {16'd0, INSTR_CNT}, 32'd0);
`endif
        step();
        CLR_N = 1'b1;

        // SC at T0 is not a wrap and not a completed sequence
        SC = 1'b1; LIMIT = 4'd7;
        step();
        SC = 1'b0;
        chk_state("sc_t0", 0, 1'b0);
`ifdef SEQ_ICNT_EN
        chk("sc_t0_icnt", {16'd0, INSTR_CNT}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
`default_nettype wire
